// File: rtl/trigger_multi.sv
// Multi-channel scope trigger: picks one sample channel, detects edge/window/external/free-run events,
// then runs qualification, auto timeout and post-trigger counting ahead of sample-memory write control.
module trigger_multi #(
    parameter int DATA_W = 8,
    parameter int NCH    = 2,
    parameter int CNT_W  = 8,
    parameter int POST_W = 16,
    parameter int ADDR_W = 16,
    parameter int AUTO_W = 20,
    localparam int SEL_W = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                  CLK,
    input  logic                  nRESET,
    input  logic                  CLK_EN,
    input  logic                  ARM,
    input  logic [NCH*DATA_W-1:0] DATA_IN,
    input  logic [SEL_W-1:0]      SRC_SEL,
    input  logic                  LA_TRIGG_IN,
    input  logic [2:0]            MODE,
    input  logic [DATA_W-1:0]     LEVEL_UP,
    input  logic [DATA_W-1:0]     LEVEL_DOWN,
    input  logic [CNT_W-1:0]      QUAL_LEN,
    input  logic [POST_W-1:0]     POST_CNT,
    input  logic                  AUTO_EN,
    input  logic [AUTO_W-1:0]     AUTO_TIMEOUT,
    output logic                  SYNC_STATE_OUT,
    output logic                  TRIG_OUT,
    output logic                  TRIG_PULSE,
    output logic                  TRIG_AUTO,
    output logic [ADDR_W-1:0]     TRIG_INDEX,
    output logic                  BUSY,
    output logic                  DONE,
    output logic [2:0]            STATE
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_QUAL = 3'd1,
        S_WAIT = 3'd2,
        S_POST = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t              r_state;
    logic [2:0]          r_mode;
    logic [SEL_W-1:0]    r_sel;
    logic [CNT_W-1:0]    r_qual_len;
    logic [POST_W-1:0]   r_post_len;
    logic                r_auto_en;
    logic [CNT_W-1:0]    r_qual_cnt;
    logic [POST_W-1:0]   r_post_cnt;
    logic [AUTO_W-1:0]   r_auto_cnt;
    logic [ADDR_W-1:0]   r_sample_cnt;
    logic                r_trig_out;
    logic                r_trig_pulse;
    logic                r_trig_auto;
    logic [ADDR_W-1:0]   r_trig_index;
    logic                r_busy;
    logic                r_done;

    logic [2:0]          w_mode;
    logic [SEL_W-1:0]    w_sel;
    logic [DATA_W-1:0]   w_sample;
    logic                w_above;
    logic                w_below;
    logic                w_inside;
    logic                w_p;
    logic                w_e;
    logic                w_free;
    logic                w_ext;
    logic                w_hunting;
    logic                w_real;
    logic                w_auto;

    function automatic logic [AUTO_W-1:0] sat_dec(input logic [AUTO_W-1:0] v);
        return (v == '0) ? v : v - 1'b1;
    endfunction

    // While idle the debug precondition follows the live configuration; once armed it uses the latched one.
    assign w_mode = (r_state == S_IDLE) ? MODE    : r_mode;
    assign w_sel  = (r_state == S_IDLE) ? SRC_SEL : r_sel;

    always_comb begin
        w_sample = DATA_IN[DATA_W-1:0];
        for (int c = 1; c < NCH; c++) begin
            if (int'(w_sel) == c) begin
                w_sample = DATA_IN[c*DATA_W +: DATA_W];
            end
        end
    end

    assign w_above  = (w_sample > LEVEL_UP);
    assign w_below  = (w_sample < LEVEL_DOWN);
    assign w_inside = (w_sample > LEVEL_DOWN) && (w_sample < LEVEL_UP);

    always_comb begin
        w_p = 1'b0;
        w_e = 1'b0;
        case (w_mode)
            3'd1: begin
                w_p = w_below;
                w_e = w_above;
            end
            3'd2: begin
                w_p = w_above;
                w_e = w_below;
            end
            3'd3: begin
                w_p = !w_inside;
                w_e = w_inside;
            end
            3'd4: begin
                w_p = w_inside;
                w_e = !w_inside;
            end
            default: begin
                w_p = 1'b0;
                w_e = 1'b0;
            end
        endcase
    end

    assign w_free    = (w_mode == 3'd0) || (w_mode[2:1] == 2'b11);
    assign w_ext     = (w_mode == 3'd5);
    assign w_hunting = (r_state == S_QUAL) || (r_state == S_WAIT);

    // A real trigger always beats the timeout when both land on the same sample.
    assign w_real = ((r_state == S_QUAL) && (w_free || (w_ext && LA_TRIGG_IN))) ||
                    ((r_state == S_WAIT) && w_e);
    assign w_auto = w_hunting && r_auto_en && (r_auto_cnt == '0);

    always_ff @(posedge CLK) begin
        if (!nRESET) begin
            r_state      <= S_IDLE;
            r_mode       <= '0;
            r_sel        <= '0;
            r_qual_len   <= '0;
            r_post_len   <= '0;
            r_auto_en    <= 1'b0;
            r_qual_cnt   <= '0;
            r_post_cnt   <= '0;
            r_auto_cnt   <= '0;
            r_sample_cnt <= '0;
            r_trig_out   <= 1'b0;
            r_trig_pulse <= 1'b0;
            r_trig_auto  <= 1'b0;
            r_trig_index <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_trig_pulse <= 1'b0;
            if (!ARM) begin
                r_state      <= S_IDLE;
                r_trig_out   <= 1'b0;
                r_trig_auto  <= 1'b0;
                r_trig_index <= '0;
                r_busy       <= 1'b0;
                r_done       <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_state      <= S_QUAL;
                        r_mode       <= MODE;
                        r_sel        <= SRC_SEL;
                        r_qual_len   <= QUAL_LEN;
                        r_post_len   <= POST_CNT;
                        r_auto_en    <= AUTO_EN;
                        r_qual_cnt   <= QUAL_LEN;
                        r_auto_cnt   <= AUTO_TIMEOUT;
                        r_sample_cnt <= '0;
                        r_busy       <= 1'b1;
                    end
                    S_QUAL, S_WAIT: begin
                        if (CLK_EN) begin
                            r_sample_cnt <= r_sample_cnt + 1'b1;
                            r_auto_cnt   <= sat_dec(r_auto_cnt);
                            if (w_real || w_auto) begin
                                r_state      <= S_POST;
                                r_trig_out   <= 1'b1;
                                r_trig_pulse <= 1'b1;
                                r_trig_auto  <= !w_real;
                                r_trig_index <= r_sample_cnt;
                                r_post_cnt   <= r_post_len;
                            end else if (r_state == S_QUAL) begin
                                // Precondition must hold for QUAL_LEN+1 consecutive samples.
                                if (!w_p) begin
                                    r_qual_cnt <= r_qual_len;
                                end else if (r_qual_cnt == '0) begin
                                    r_state <= S_WAIT;
                                end else begin
                                    r_qual_cnt <= r_qual_cnt - 1'b1;
                                end
                            end
                        end
                    end
                    S_POST: begin
                        if (CLK_EN) begin
                            r_sample_cnt <= r_sample_cnt + 1'b1;
                            if (r_post_cnt == '0) begin
                                r_state <= S_DONE;
                                r_busy  <= 1'b0;
                                r_done  <= 1'b1;
                            end else begin
                                r_post_cnt <= r_post_cnt - 1'b1;
                            end
                        end
                    end
                    S_DONE: begin
                        r_state <= S_DONE;
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign SYNC_STATE_OUT = w_p;
    assign TRIG_OUT       = r_trig_out;
    assign TRIG_PULSE     = r_trig_pulse;
    assign TRIG_AUTO      = r_trig_auto;
    assign TRIG_INDEX     = r_trig_index;
    assign BUSY           = r_busy;
    assign DONE           = r_done;
    assign STATE          = r_state;

endmodule

// File: tb/tb_trigger_multi.sv
// Directed bench for trigger_multi: an event-level model derives trigger/qualify/done sample edges
// from the trigger rules, and a negedge process compares every output against it each cycle.
module tb_trigger_multi;
    localparam int BIG = 1 << 30;

    logic        CLK = 1'b0;
    logic        nRESET, CLK_EN, ARM, LA_TRIGG_IN, AUTO_EN;
    logic [15:0] DATA_IN;
    logic [0:0]  SRC_SEL;
    logic [2:0]  MODE;
    logic [7:0]  LEVEL_UP, LEVEL_DOWN, QUAL_LEN;
    logic [15:0] POST_CNT;
    logic [19:0] AUTO_TIMEOUT;
    logic        SYNC_STATE_OUT, TRIG_OUT, TRIG_PULSE, TRIG_AUTO, BUSY, DONE;
    logic [15:0] TRIG_INDEX;
    logic [2:0]  STATE;

    trigger_multi dut (
        .CLK(CLK), .nRESET(nRESET), .CLK_EN(CLK_EN), .ARM(ARM), .DATA_IN(DATA_IN),
        .SRC_SEL(SRC_SEL), .LA_TRIGG_IN(LA_TRIGG_IN), .MODE(MODE), .LEVEL_UP(LEVEL_UP),
        .LEVEL_DOWN(LEVEL_DOWN), .QUAL_LEN(QUAL_LEN), .POST_CNT(POST_CNT), .AUTO_EN(AUTO_EN),
        .AUTO_TIMEOUT(AUTO_TIMEOUT), .SYNC_STATE_OUT(SYNC_STATE_OUT), .TRIG_OUT(TRIG_OUT),
        .TRIG_PULSE(TRIG_PULSE), .TRIG_AUTO(TRIG_AUTO), .TRIG_INDEX(TRIG_INDEX), .BUSY(BUSY),
        .DONE(DONE), .STATE(STATE)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_errors = 0;

    // configuration of the current case
    int c_mode, c_sel, c_dn, c_up, c_ql, c_post, c_aen, c_tmo;
    // per-edge stimulus; index = edge number, edge 0 is the arming edge
    int en_a[64], d0_a[64], d1_a[64], la_a[64];
    // model events (edge numbers)
    int ev_qual, ev_trig, ev_done, ev_idx;
    bit ev_auto;
    // expected outputs
    logic [2:0]  exp_state;
    logic [15:0] exp_idx;
    bit exp_busy, exp_done, exp_tout, exp_tpulse, exp_tauto, exp_sync;
    bit chk_en = 0;
    // observations for literal checks
    int pulses, cap_idx, cap_auto, cap_edge, done_edge;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void cond(input int m, input int d, input int dn, input int up,
                                 output bit p, output bit e);
        bit inw;
        inw = (d > dn) && (d < up);
        case (m)
            1: begin p = d < dn; e = d > up; end
            2: begin p = d > up; e = d < dn; end
            3: begin p = !inw;   e = inw;    end
            4: begin p = inw;    e = !inw;   end
            default: begin p = 0; e = 0; end
        endcase
    endfunction

    function automatic int sel_data(input int c);
        return (c_sel == 1) ? d1_a[c] : d0_a[c];
    endfunction

    // Walk the enabled samples and apply the trigger rules directly.
    task automatic model_scan(input int n, input int kill);
        int run, k, pk;
        bit qualified, real_t, p, e;
        ev_qual = BIG; ev_trig = BIG; ev_done = BIG; ev_idx = 0; ev_auto = 0;
        run = 0; k = 0; pk = 0; qualified = 0;
        for (int c = 1; c <= n && c < kill; c++) begin
            if (en_a[c] == 0 || ev_done != BIG) continue;
            cond(c_mode, sel_data(c), c_dn, c_up, p, e);
            if (ev_trig == BIG) begin
                real_t = 0;
                if (qualified) real_t = e;
                else if (c_mode == 0 || c_mode >= 6) real_t = 1;
                else if (c_mode == 5) real_t = (la_a[c] != 0);
                else if (p) begin
                    run++;
                    if (run == c_ql + 1) begin qualified = 1; ev_qual = c; end
                end else run = 0;
                if (real_t || (c_aen != 0 && k >= c_tmo)) begin
                    ev_trig = c; ev_auto = !real_t; ev_idx = k;
                end
                k++;
            end else begin
                pk++;
                if (pk == c_post + 1) ev_done = c;
            end
        end
    endtask

    task automatic set_exp(input int e, input int kill);
        int st;
        if (e < 0 || e >= kill) st = 0;
        else if (e >= ev_done) st = 4;
        else if (e >= ev_trig) st = 3;
        else if (e >= ev_qual) st = 2;
        else st = 1;
        exp_state  = st[2:0];
        exp_busy   = (st >= 1 && st <= 3);
        exp_done   = (st == 4);
        exp_tout   = (st >= 3);
        exp_tpulse = (st != 0) && (e == ev_trig);
        exp_tauto  = exp_tout && ev_auto;
        exp_idx    = exp_tout ? ev_idx[15:0] : 16'd0;
    endtask

    always @(negedge CLK) begin
        if (chk_en) begin
            check("STATE", STATE, exp_state);
            check("BUSY", BUSY, exp_busy);
            check("DONE", DONE, exp_done);
            check("TRIG_OUT", TRIG_OUT, exp_tout);
            check("TRIG_PULSE", TRIG_PULSE, exp_tpulse);
            check("TRIG_AUTO", TRIG_AUTO, exp_tauto);
            check("TRIG_INDEX", TRIG_INDEX, exp_idx);
            check("SYNC_STATE_OUT", SYNC_STATE_OUT, exp_sync);
        end
    end

    task automatic cfg(input int m, input int s, input int dn, input int up, input int ql,
                       input int post, input int aen, input int tmo);
        c_mode = m; c_sel = s; c_dn = dn; c_up = up; c_ql = ql; c_post = post; c_aen = aen; c_tmo = tmo;
        for (int i = 0; i < 64; i++) begin en_a[i] = 0; d0_a[i] = 0; d1_a[i] = 0; la_a[i] = 0; end
    endtask

    task automatic fill(input int a, input int b, input int en, input int d0, input int d1, input int la);
        for (int i = a; i <= b; i++) begin en_a[i] = en; d0_a[i] = d0; d1_a[i] = d1; la_a[i] = la; end
    endtask

    task automatic run_case(input int n, input int kill, input bit by_reset);
        bit p, e;
        model_scan(n, kill);
        MODE = 3'(c_mode); SRC_SEL = 1'(c_sel); LEVEL_DOWN = 8'(c_dn); LEVEL_UP = 8'(c_up);
        QUAL_LEN = 8'(c_ql); POST_CNT = 16'(c_post); AUTO_EN = (c_aen != 0); AUTO_TIMEOUT = 20'(c_tmo);
        pulses = 0; cap_idx = -1; cap_auto = -1; cap_edge = -1; done_edge = -1;
        for (int c = 0; c <= n; c++) begin
            CLK_EN      = (en_a[c] != 0);
            DATA_IN     = {8'(d1_a[c]), 8'(d0_a[c])};
            LA_TRIGG_IN = (la_a[c] != 0);
            ARM         = by_reset ? (c <= kill) : (c < kill);
            nRESET      = !(by_reset && c == kill);
            set_exp(c - 1, kill);
            cond(c_mode, sel_data(c), c_dn, c_up, p, e);
            exp_sync = p;
            chk_en = 1;
            @(posedge CLK); #1;
            if (TRIG_PULSE) begin pulses++; cap_idx = TRIG_INDEX; cap_auto = TRIG_AUTO; cap_edge = c; end
            if (DONE && done_edge < 0) done_edge = c;
        end
        nRESET = 1; ARM = 0; CLK_EN = 0; LA_TRIGG_IN = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        nRESET = 0; ARM = 1; CLK_EN = 1; LA_TRIGG_IN = 0; AUTO_EN = 0; DATA_IN = '0; SRC_SEL = '0;
        MODE = '0; LEVEL_UP = '0; LEVEL_DOWN = '0; QUAL_LEN = '0; POST_CNT = '0; AUTO_TIMEOUT = '0;
        repeat (2) @(posedge CLK);
        #1;
        check("rst_STATE", STATE, 0);
        check("rst_TRIG_OUT", TRIG_OUT, 0);
        check("rst_BUSY", BUSY, 0);
        cfg(0, 0, 0, 0, 0, 0, 0, 0);
        set_exp(-1, 0);
        exp_sync = 0;
        chk_en = 1;
        @(posedge CLK); #1;
        nRESET = 1; ARM = 0; CLK_EN = 0;
        @(posedge CLK); #1;

        // rising edge with qualification and a hysteresis sample; ch1 carries a decoy
        cfg(1, 0, 40, 80, 2, 2, 0, 0);
        fill(1, 12, 1, 90, 90, 0); fill(1, 3, 1, 20, 90, 0); fill(4, 4, 1, 60, 90, 0);
        run_case(12, 11, 0);
        check("t1_pulses", pulses, 1);
        check("t1_index", cap_idx, 4);
        check("t1_auto", cap_auto, 0);
        check("t1_edge", cap_edge, 5);

        // window-in: inside-window samples break qualification, no trigger
        cfg(3, 0, 40, 80, 3, 0, 0, 0);
        fill(1, 11, 1, 60, 0, 0); fill(1, 2, 1, 100, 0, 0); fill(4, 6, 1, 100, 0, 0);
        run_case(11, 10, 0);
        check("t2_pulses", pulses, 0);

        // falling, never qualifies, auto timeout after 5 samples
        cfg(2, 0, 40, 80, 0, 1, 1, 5);
        fill(1, 11, 1, 50, 50, 0);
        run_case(11, 10, 0);
        check("t3_index", cap_idx, 5);
        check("t3_auto", cap_auto, 1);
        check("t3_edge", cap_edge, 6);

        // free-run with CLK_EN on every second clock
        cfg(0, 0, 40, 80, 0, 3, 0, 0);
        for (int c = 2; c <= 14; c += 2) fill(c, c, 1, 33, 0, 0);
        run_case(14, 13, 0);
        check("t4_edge", cap_edge, 2);
        check("t4_done_edge", done_edge, 10);
        check("t4_index", cap_idx, 0);

        // external: LA request ignored while CLK_EN=0
        cfg(5, 0, 40, 80, 0, 0, 0, 0);
        fill(1, 8, 1, 70, 0, 0); fill(2, 3, 0, 70, 0, 1); fill(4, 4, 1, 70, 0, 1);
        run_case(8, 7, 0);
        check("t5_edge", cap_edge, 4);
        check("t5_index", cap_idx, 1);
        check("t5_done_edge", done_edge, 5);

        // ARM dropped during POST
        cfg(0, 0, 40, 80, 0, 10, 0, 0);
        fill(1, 6, 1, 10, 0, 0);
        run_case(6, 4, 0);
        check("t6a_pulses", pulses, 1);
        check("t6a_STATE", STATE, 0);
        check("t6a_TRIG_OUT", TRIG_OUT, 0);

        // reset while waiting in the hysteresis band
        cfg(1, 0, 40, 80, 0, 0, 0, 0);
        fill(1, 6, 1, 60, 0, 0); fill(1, 1, 1, 20, 0, 0);
        run_case(6, 4, 1);
        check("t6b_pulses", pulses, 0);
        check("t6b_STATE", STATE, 0);
        check("t6b_DONE", DONE, 0);

        // real trigger and timeout on the same sample: real wins
        cfg(1, 0, 40, 80, 0, 0, 1, 2);
        fill(1, 7, 1, 90, 0, 0); fill(1, 1, 1, 20, 0, 0); fill(2, 2, 1, 60, 0, 0);
        run_case(7, 6, 0);
        check("t7_index", cap_idx, 2);
        check("t7_auto", cap_auto, 0);
        check("t7_edge", cap_edge, 3);

        // window-out on channel 1, with a gated sample that would otherwise trigger
        cfg(4, 1, 40, 80, 1, 1, 0, 0);
        fill(1, 10, 1, 100, 100, 0); fill(1, 2, 1, 100, 60, 0); fill(3, 3, 0, 100, 100, 0);
        fill(4, 4, 1, 100, 60, 0);
        run_case(10, 9, 0);
        check("t8_edge", cap_edge, 5);
        check("t8_index", cap_idx, 3);
        check("t8_done_edge", done_edge, 7);

        chk_en = 0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
